// File: rtl/fp_to_int_hs.sv
// Floating-point to integer converter with stb/ack handshakes on both channels.
// Supports truncation or round-to-nearest-even, signed/unsigned output, saturation and {invalid, overflow, inexact} flags.
module fp_to_int_hs #(
    parameter int EXP_W      = 8,
    parameter int MAN_W      = 23,
    parameter int INT_W      = 32,
    parameter bit SIGNED_OUT = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [EXP_W+MAN_W:0]   input_a,
    input  logic                   input_a_stb,
    output logic                   input_a_ack,
    input  logic                   rnd_mode,
    output logic [INT_W-1:0]       output_z,
    output logic                   output_z_stb,
    input  logic                   output_z_ack,
    output logic [2:0]             output_flags
);

    localparam int FW   = 1 + EXP_W + MAN_W;
    localparam int EW   = EXP_W + 2;
    localparam int SH_W = $clog2(INT_W + 1);
    localparam int WIDE = MAN_W + 1 + INT_W;
    localparam int MW   = INT_W + 2;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;

    localparam logic signed [EW-1:0] BIAS_S   = EW'(BIAS);
    localparam logic [INT_W-1:0]     ALL_ONES = {INT_W{1'b1}};
    localparam logic [INT_W-1:0]     S_MIN    = {1'b1, {(INT_W-1){1'b0}}};
    localparam logic [INT_W-1:0]     POS_SAT  = SIGNED_OUT ? (ALL_ONES >> 1) : ALL_ONES;
    localparam logic [INT_W-1:0]     NEG_SAT  = SIGNED_OUT ? S_MIN : {INT_W{1'b0}};
    localparam logic [MW-1:0]        POS_LIM  = MW'(POS_SAT);
    localparam logic [MW-1:0]        NEG_LIM  = MW'(NEG_SAT);

    typedef enum logic [2:0] {GET_A, UNPACK, ALIGN, ROUND, PUT_Z} state_t;
    typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} cls_t;

    state_t state, state_n;
    logic   accept, deliver;

    // Captured operand
    logic [FW-1:0]    a_q;
    logic             rnd_q;

    // Unpack stage
    logic                 sign_u;
    logic signed [EW-1:0] e_u;
    logic [MAN_W-1:0]     frac_u;
    cls_t                 cls_u;

    // Align stage
    logic             sign_l;
    cls_t             cls_l;
    logic [INT_W:0]   int_l;
    logic             guard_l, sticky_l, big_l;

    // Combinational stage results
    logic [EXP_W-1:0]     exp_f;
    logic [MAN_W-1:0]     frac_f;
    logic signed [EW-1:0] e_n;
    cls_t                 cls_n;
    logic [WIDE-1:0]      wide;
    logic [INT_W:0]       int_n;
    logic                 guard_n, sticky_n, big_n;
    int                   e_int;
    logic                 inc;
    logic [MW-1:0]        mag;
    logic [INT_W-1:0]     z_n;
    logic [2:0]           flags_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= GET_A;
        else     state <= state_n;
    end

    // NOTE: every signal driven in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        deliver = 1'b0;
        case (state)
            GET_A: begin
                if (input_a_stb && input_a_ack) begin
                    accept  = 1'b1;
                    state_n = UNPACK;
                end
            end
            UNPACK: state_n = ALIGN;
            ALIGN:  state_n = ROUND;
            ROUND:  state_n = PUT_Z;
            PUT_Z: begin
                if (output_z_stb && output_z_ack) begin
                    deliver = 1'b1;
                    state_n = GET_A;
                end
            end
            default: state_n = GET_A;
        endcase
    end

    always_comb begin
        exp_f  = a_q[FW-2:MAN_W];
        frac_f = a_q[MAN_W-1:0];
        e_n    = $signed({2'b00, exp_f}) - BIAS_S;
        if (exp_f == '0)
            cls_n = CLS_ZERO;
        else if (exp_f == '1)
            cls_n = (frac_f != '0) ? CLS_NAN : CLS_INF;
        else
            cls_n = CLS_NORM;
    end

    // Exponents past INT_W cannot fit in either output format, so they skip the shifter.
    always_comb begin
        int_n    = '0;
        guard_n  = 1'b0;
        sticky_n = 1'b0;
        big_n    = 1'b0;
        wide     = '0;
        e_int    = int'(e_u);
        case (cls_u)
            CLS_ZERO: sticky_n = |frac_u;
            CLS_NORM: begin
                if (e_int > INT_W) begin
                    big_n = 1'b1;
                end else if (e_int >= 0) begin
                    wide     = WIDE'({1'b1, frac_u}) << e_u[SH_W-1:0];
                    int_n    = wide[WIDE-1:MAN_W];
                    guard_n  = wide[MAN_W-1];
                    sticky_n = |wide[MAN_W-2:0];
                end else if (e_int == -1) begin
                    guard_n  = 1'b1;
                    sticky_n = |frac_u;
                end else begin
                    sticky_n = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        inc     = rnd_q && guard_l && (sticky_l || int_l[0]);
        mag     = {1'b0, int_l} + MW'(inc);
        z_n     = '0;
        flags_n = 3'b000;
        case (cls_l)
            CLS_NAN: begin
                flags_n = 3'b100;
                z_n     = SIGNED_OUT ? S_MIN : ALL_ONES;
            end
            CLS_INF: begin
                flags_n = 3'b100;
                z_n     = sign_l ? NEG_SAT : POS_SAT;
            end
            default: begin
                if (big_l || (sign_l ? (mag > NEG_LIM) : (mag > POS_LIM))) begin
                    flags_n = 3'b010;
                    z_n     = sign_l ? NEG_SAT : POS_SAT;
                end else begin
                    z_n     = sign_l ? -mag[INT_W-1:0] : mag[INT_W-1:0];
                    flags_n = {2'b00, guard_l | sticky_l};
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q          <= '0;
            rnd_q        <= 1'b0;
            sign_u       <= 1'b0;
            e_u          <= '0;
            frac_u       <= '0;
            cls_u        <= CLS_ZERO;
            sign_l       <= 1'b0;
            cls_l        <= CLS_ZERO;
            int_l        <= '0;
            guard_l      <= 1'b0;
            sticky_l     <= 1'b0;
            big_l        <= 1'b0;
            input_a_ack  <= 1'b0;
            output_z     <= '0;
            output_z_stb <= 1'b0;
            output_flags <= 3'b000;
        end else begin
            if (state == GET_A && !input_a_ack)
                input_a_ack <= 1'b1;
            if (accept) begin
                a_q         <= input_a;
                rnd_q       <= rnd_mode;
                input_a_ack <= 1'b0;
            end
            if (state == UNPACK) begin
                sign_u <= a_q[FW-1];
                e_u    <= e_n;
                frac_u <= frac_f;
                cls_u  <= cls_n;
            end
            if (state == ALIGN) begin
                sign_l   <= sign_u;
                cls_l    <= cls_u;
                int_l    <= int_n;
                guard_l  <= guard_n;
                sticky_l <= sticky_n;
                big_l    <= big_n;
            end
            if (state == ROUND) begin
                output_z     <= z_n;
                output_flags <= flags_n;
            end
            // Strobe rises one cycle after the result registers settle.
            if (state == PUT_Z && !output_z_stb)
                output_z_stb <= 1'b1;
            if (deliver) begin
                output_z_stb <= 1'b0;
                input_a_ack  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp_to_int_hs.sv
// Self-checking bench for fp_to_int_hs: signed single, unsigned single and signed double instances,
// directed corner vectors plus randomized operands compared against an exact fixed-point model.
module tb_fp_to_int_hs;

    logic        clk;
    logic        rst;
    logic [63:0] a_bus;
    logic        rnd_bus;
    logic [2:0]  a_stb;
    logic [2:0]  a_ack;
    logic [2:0]  z_stb;
    logic [2:0]  z_ack;
    logic [31:0] z_s, z_u;
    logic [63:0] z_d;
    logic [2:0]  f_s, f_u, f_d;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct {
        int          d;
        logic [63:0] a;
        logic        rnd;
        logic [63:0] z;
        logic [2:0]  f;
    } vec_t;

    vec_t vecs[$];

    fp_to_int_hs #(.EXP_W(8), .MAN_W(23), .INT_W(32), .SIGNED_OUT(1'b1)) dut_s (
        .clk(clk), .rst(rst), .input_a(a_bus[31:0]), .input_a_stb(a_stb[0]),
        .input_a_ack(a_ack[0]), .rnd_mode(rnd_bus), .output_z(z_s),
        .output_z_stb(z_stb[0]), .output_z_ack(z_ack[0]), .output_flags(f_s));

    fp_to_int_hs #(.EXP_W(8), .MAN_W(23), .INT_W(32), .SIGNED_OUT(1'b0)) dut_u (
        .clk(clk), .rst(rst), .input_a(a_bus[31:0]), .input_a_stb(a_stb[1]),
        .input_a_ack(a_ack[1]), .rnd_mode(rnd_bus), .output_z(z_u),
        .output_z_stb(z_stb[1]), .output_z_ack(z_ack[1]), .output_flags(f_u));

    fp_to_int_hs #(.EXP_W(11), .MAN_W(52), .INT_W(64), .SIGNED_OUT(1'b1)) dut_d (
        .clk(clk), .rst(rst), .input_a(a_bus), .input_a_stb(a_stb[2]),
        .input_a_ack(a_ack[2]), .rnd_mode(rnd_bus), .output_z(z_d),
        .output_z_stb(z_stb[2]), .output_z_ack(z_ack[2]), .output_flags(f_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] get_z(input int d);
        case (d)
            0:       return 64'(z_s);
            1:       return 64'(z_u);
            default: return z_d;
        endcase
    endfunction

    function automatic logic [2:0] get_f(input int d);
        case (d)
            0:       return f_s;
            1:       return f_u;
            default: return f_d;
        endcase
    endfunction

    function automatic void dut_params(input int d, output int ew, output int mw,
                                       output int iw, output bit so);
        case (d)
            0:       begin ew = 8;  mw = 23; iw = 32; so = 1'b1; end
            1:       begin ew = 8;  mw = 23; iw = 32; so = 1'b0; end
            default: begin ew = 11; mw = 52; iw = 64; so = 1'b1; end
        endcase
    endfunction

    // Exact model: scale the value to a fixed-point number with MAN_W+2 fraction bits,
    // round by comparing the discarded part against one half, then range-check.
    function automatic void ref_model(input int d, input logic [63:0] a, input logic rnd,
                                      output logic [63:0] z, output logic [2:0] f);
        int           ew, mw, iw, bias, e;
        bit           so, sign, lost, ovf;
        logic [63:0]  mask, exp_v, frac;
        logic [191:0] mant, fx, ip, fr, half, pos_lim, neg_lim;
        dut_params(d, ew, mw, iw, so);
        mask    = (iw == 64) ? '1 : ((64'd1 << iw) - 64'd1);
        sign    = a[ew+mw];
        exp_v   = (a >> mw) & ((64'd1 << ew) - 64'd1);
        frac    = a & ((64'd1 << mw) - 64'd1);
        bias    = (1 << (ew - 1)) - 1;
        e       = int'(exp_v) - bias;
        pos_lim = so ? ((192'd1 << (iw - 1)) - 192'd1) : ((192'd1 << iw) - 192'd1);
        neg_lim = so ? (192'd1 << (iw - 1)) : 192'd0;
        z = '0; f = 3'b000; lost = 1'b0; ovf = 1'b0; ip = '0;
        if (exp_v == ((64'd1 << ew) - 64'd1)) begin
            f = 3'b100;
            if (frac != 0) z = so ? (64'd1 << (iw - 1)) : mask;
            else           z = sign ? neg_lim[63:0] : pos_lim[63:0];
        end else begin
            if (exp_v == 0) begin
                lost = (frac != 0);
            end else if (e > iw + 2) begin
                ovf = 1'b1;
            end else if (e < -2) begin
                lost = 1'b1;
            end else begin
                mant = 192'(frac) | (192'd1 << mw);
                fx   = mant << (e + 2);
                ip   = fx >> (mw + 2);
                fr   = fx & ((192'd1 << (mw + 2)) - 192'd1);
                half = 192'd1 << (mw + 1);
                lost = (fr != 0);
                if (rnd && (fr > half || (fr == half && ip[0]))) ip = ip + 192'd1;
            end
            if (!ovf) ovf = sign ? (ip > neg_lim) : (ip > pos_lim);
            if (ovf) begin
                f = 3'b010;
                z = sign ? neg_lim[63:0] : pos_lim[63:0];
            end else begin
                f = {2'b00, lost};
                z = sign ? ((64'd0 - ip[63:0]) & mask) : ip[63:0];
            end
        end
    endfunction

    function automatic logic [63:0] rand_op(input int d);
        int          ew, mw, iw, bias, e, k;
        bit          so;
        logic [63:0] frac, exp_v, sign;
        dut_params(d, ew, mw, iw, so);
        bias = (1 << (ew - 1)) - 1;
        frac = {$urandom, $urandom} & ((64'd1 << mw) - 64'd1);
        if ($urandom_range(0, 3) == 0)
            frac = frac & ~((64'd1 << $urandom_range(0, mw)) - 64'd1);
        k = int'($urandom_range(0, 15));
        if (k == 0)      exp_v = '0;
        else if (k == 1) exp_v = (64'd1 << ew) - 64'd1;
        else begin
            e     = int'($urandom_range(0, iw + 6)) - 3;
            exp_v = 64'(bias + e);
        end
        sign = 64'($urandom_range(0, 1));
        return (sign << (ew + mw)) | (exp_v << mw) | frac;
    endfunction

    // One full transaction on instance d; hold = cycles the result is left unacknowledged.
    task automatic do_conv(input int d, input logic [63:0] a, input logic rnd, input int hold,
                           input logic [63:0] ez, input logic [2:0] ef, input string tag);
        bit          got_ack, got_stb, stable;
        int          lat;
        logic [63:0] z_seen;
        logic [2:0]  f_seen;
        a_bus    = a;
        rnd_bus  = rnd;
        a_stb[d] = 1'b1;
        got_ack  = 1'b0;
        for (int i = 0; i < 16 && !got_ack; i++) begin
            @(negedge clk);
            got_ack = a_ack[d];
        end
        check({tag, "_accept"}, 64'(got_ack), 64'd1);
        if (!got_ack) begin
            a_stb[d] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        a_stb[d] = 1'b0;
        a_bus    = {$urandom, $urandom};
        rnd_bus  = ~rnd;
        z_ack[d] = (hold == 0);
        got_stb  = 1'b0;
        lat      = 0;
        for (int i = 1; i <= 16 && !got_stb; i++) begin
            @(posedge clk); #1;
            lat     = i;
            got_stb = z_stb[d];
        end
        check({tag, "_lat"}, 64'(lat), 64'd4);
        if (!got_stb) begin
            z_ack[d] = 1'b0;
            return;
        end
        z_seen = get_z(d);
        f_seen = get_f(d);
        check({tag, "_z"}, z_seen, ez);
        check({tag, "_flags"}, 64'(f_seen), 64'(ef));
        if (hold > 0) begin
            stable   = 1'b1;
            a_stb[d] = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                if (get_z(d) !== z_seen || get_f(d) !== f_seen || !z_stb[d] || a_ack[d])
                    stable = 1'b0;
            end
            a_stb[d] = 1'b0;
            check({tag, "_hold"}, 64'(stable), 64'd1);
        end
        z_ack[d] = 1'b1;
        @(posedge clk); #1;
        z_ack[d] = 1'b0;
        check({tag, "_done"}, {62'd0, z_stb[d], a_ack[d]}, 64'd1);
    endtask

    initial begin
        bit          got, stale;
        logic [63:0] a, ez;
        logic [2:0]  ef;
        logic        rnd;

        rst = 1'b1; a_bus = '0; rnd_bus = 1'b0; a_stb = '0; z_ack = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_single", 64'({a_ack[0], z_stb[0], f_s, z_s}), 64'd0);
        check("rst_double", 64'({a_ack[2], z_stb[2], f_d}) | z_d, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("ack_low_after_release", 64'(a_ack), 64'd0);
        @(posedge clk); #1;
        check("ack_high_first_edge", 64'(a_ack), 64'd7);

        vecs.push_back('{0, 64'h40490FDB, 1'b0, 64'h00000003, 3'b001});
        vecs.push_back('{0, 64'h40200000, 1'b1, 64'h00000002, 3'b001});
        vecs.push_back('{0, 64'h40600000, 1'b1, 64'h00000004, 3'b001});
        vecs.push_back('{0, 64'hCF000000, 1'b0, 64'h80000000, 3'b000});
        vecs.push_back('{0, 64'h4F000000, 1'b0, 64'h7FFFFFFF, 3'b010});
        vecs.push_back('{0, 64'h7FC00000, 1'b0, 64'h80000000, 3'b100});
        vecs.push_back('{0, 64'hFF800000, 1'b1, 64'h80000000, 3'b100});
        vecs.push_back('{0, 64'h7F800000, 1'b0, 64'h7FFFFFFF, 3'b100});
        vecs.push_back('{0, 64'hCF000001, 1'b0, 64'h80000000, 3'b010});
        vecs.push_back('{0, 64'h3F000000, 1'b1, 64'h00000000, 3'b001});
        vecs.push_back('{0, 64'h3F400000, 1'b1, 64'h00000001, 3'b001});
        vecs.push_back('{0, 64'h00000001, 1'b1, 64'h00000000, 3'b001});
        vecs.push_back('{1, 64'hC0000000, 1'b0, 64'h00000000, 3'b010});
        vecs.push_back('{1, 64'hBF000000, 1'b1, 64'h00000000, 3'b001});
        vecs.push_back('{1, 64'h7FC00000, 1'b0, 64'hFFFFFFFF, 3'b100});
        vecs.push_back('{1, 64'h4F800000, 1'b0, 64'hFFFFFFFF, 3'b010});
        vecs.push_back('{1, 64'h4F7FFFFF, 1'b1, 64'hFFFFFF00, 3'b000});
        vecs.push_back('{2, 64'hC00C000000000000, 1'b1, 64'hFFFFFFFFFFFFFFFC, 3'b001});
        foreach (vecs[i])
            do_conv(vecs[i].d, vecs[i].a, vecs[i].rnd, 0, vecs[i].z, vecs[i].f,
                    $sformatf("dir%0d", i));

        do_conv(0, 64'h40490FDB, 1'b0, 10, 64'h3, 3'b001, "hold");

        // Reset while the operand sits in the align stage.
        a_bus = 64'h40490FDB; rnd_bus = 1'b0; a_stb[0] = 1'b1; got = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            got = a_ack[0];
        end
        check("rst_mid_accept", 64'(got), 64'd1);
        @(posedge clk); #1;
        a_stb[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1 check("rst_mid_outputs", 64'({a_ack[0], z_stb[0], f_s, z_s}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst_mid_ack_low", 64'(a_ack[0]), 64'd0);
        @(posedge clk); #1;
        check("rst_mid_ack_high", 64'(a_ack[0]), 64'd1);
        stale = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (z_stb[0]) stale = 1'b1;
        end
        check("rst_mid_no_stale", 64'(stale), 64'd0);

        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 150; n++) begin
                a   = rand_op(d);
                rnd = 1'($urandom_range(0, 1));
                ref_model(d, a, rnd, ez, ef);
                do_conv(d, a, rnd, int'($urandom_range(0, 2)), ez, ef,
                        $sformatf("rnd%0d_%0d_a%0h", d, n, a));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/fp_to_int_hs.md
Name: fp_to_int_hs

Overview:
- Parametrised floating-point to integer converter with stb/ack handshakes on its input and output channels.
- Same handshake style as the FP arithmetic units; it is the single-operand unit the top-level process select dispatches to.
- EXP_W/MAN_W set the input format: 8/23 for single, 11/52 for double.
- Adds selectable rounding, signed/unsigned output, saturation and exception flags, none of which the current units have.

Parameters:
EXP_W, 8, exponent field width; bias = 2^(EXP_W-1)-1
MAN_W, 23, fraction field width; FW = 1+EXP_W+MAN_W
INT_W, 32, output integer width
SIGNED_OUT, 1, 1 = two's-complement result, 0 = unsigned result

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
input_a  in  FW  IEEE-754 style operand
input_a_stb  in  1  operand valid
input_a_ack  out  1  unit ready to take operand
rnd_mode  in  1  0 = toward zero, 1 = nearest-even; sampled with input_a
output_z  out  INT_W  integer result
output_z_stb  out  1  result valid
output_z_ack  in  1  consumer accepts result
output_flags  out  3  {invalid, overflow, inexact}, valid with output_z_stb

Behaviour:
- Reset (async, rst=1): state GET_A; all outputs 0, including input_a_ack. input_a_ack rises on the first clk edge after rst falls.
- FSM: GET_A -> UNPACK -> ALIGN -> ROUND -> PUT_Z -> GET_A.
- GET_A: input_a_ack=1. On an edge with input_a_stb&&input_a_ack:
  - capture input_a and rnd_mode;
  - drop input_a_ack;
  - go to UNPACK.
- UNPACK: split sign/exp/frac; e = exp - bias; classify zero/denormal, normal, Inf, NaN.
- ALIGN: form {1,frac} and barrel-shift by e to an integer part plus guard and sticky bits.
- ROUND:
  - RTZ: truncate.
  - RNE: increment if guard=1 and (sticky=1 or integer LSB=1).
  - Negate when sign=1 and SIGNED_OUT.
  - Range-check after rounding.
- PUT_Z: output_z_stb=1; output_z and output_flags stay stable until an edge with output_z_stb&&output_z_ack. Then clear output_z_stb and go to GET_A.
- Latency: output_z_stb rises exactly 4 edges after the accepting edge. Throughput is one conversion per 6 cycles when output_z_ack is held high.
- Zero or denormal: z=0, inexact=1 if frac!=0. RNE never rounds a denormal up.
- NaN (exp all ones, frac!=0): invalid=1; z=2^(INT_W-1) pattern if signed, all ones if unsigned.
- Inf: invalid=1; z saturates to MAX (+Inf) or MIN (-Inf).
- Signed range:
  - valid range is -2^(INT_W-1) .. 2^(INT_W-1)-1; exactly -2^(INT_W-1) is valid with no flags;
  - a rounded magnitude outside the range gives overflow=1 and z saturated to MAX/MIN.
- Unsigned:
  - negative input whose rounded value is nonzero: overflow=1, z=0;
  - negative input rounding to 0: z=0, inexact only;
  - above 2^INT_W-1: overflow=1, z=all ones.
- Flag exclusivity: inexact=1 whenever discarded fraction bits are nonzero and neither invalid nor overflow is set; invalid and overflow are mutually exclusive.
- Shift guard: e >= INT_W+1 forces the overflow path without shifting, so no shift amount exceeds INT_W+MAN_W.
- Output hold: output_z_ack while output_z_stb=0 is ignored. input_a_stb outside GET_A is ignored; input_a_ack stays 0.
- Reset mid-operation: pending operand is discarded, outputs clear immediately, no stale result is emitted afterwards.

Test Plan:
- Default params, input_a=0x40490FDB (3.14159), rnd_mode=0 -> output_z=0x00000003, flags=001; output_z_stb high 4 edges after accept.
- rnd_mode=1: 0x40200000 (2.5) -> 0x00000002; 0x40600000 (3.5) -> 0x00000004; both flags=001.
- 0xCF000000 (-2^31) -> 0x80000000, flags=000; 0x4F000000 (2^31) -> 0x7FFFFFFF, flags=010.
- 0x7FC00000 (NaN) -> 0x80000000, flags=100; 0xFF800000 (-Inf) -> 0x80000000, flags=100; SIGNED_OUT=0 with 0xC0000000 (-2.0) -> 0x00000000, flags=010.
- output_z_ack held 0 for 10 cycles after output_z_stb -> output_z/flags stable, input_a_ack=0 throughout; new operand accepted only after the ack edge. Assert rst during ALIGN -> all outputs 0 at once, input_a_ack=1 one edge after release.
- EXP_W=11, MAN_W=52, INT_W=64, rnd_mode=1: input_a=0xC00C000000000000 (-3.5) -> 0xFFFFFFFFFFFFFFFC, flags=001.
